fifo_wr_mem_ctrl: RTL and testbench
===================================

# fifo_wr_mem_ctrl

Write-domain half of the asynchronous FIFO, clocked by w_clk. It combines a parametrised dual-port storage array with the write pointer, the Gray-coded pointer export, the read-pointer synchroniser and the full/almost-full/occupancy/overflow status logic. The read-domain controller supplies its Gray pointer and binary read address. Data reads combinationally out of the array into the read domain.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each FIFO word
- ADDR_WIDTH, 3, address bits; depth = 2^ADDR_WIDTH; legal range ≥ 2
- SYNC_STAGES, 2, flop stages synchronising r_gptr into w_clk; legal range ≥ 2
- AFULL_THRESH, 6, occupancy at or above which w_afull asserts; legal range 1..2^ADDR_WIDTH

Ports:
- w_clk  in  1  write clock
- w_rst  in  1  asynchronous, active-low reset
- w_inc  in  1  write request
- w_data  in  DATA_WIDTH  write data
- w_ovf_clr  in  1  synchronous clear of sticky overflow flag
- r_addr  in  ADDR_WIDTH  binary read address from read domain
- r_gptr  in  ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous to w_clk)
- r_data  out  DATA_WIDTH  combinational array[r_addr]
- w_gptr  out  ADDR_WIDTH+1  registered Gray write pointer, for the read domain
- w_full  out  1  FIFO full, registered
- w_afull  out  1  occupancy ≥ AFULL_THRESH, registered
- w_count  out  ADDR_WIDTH+1  write-side occupancy, registered, 0..2^ADDR_WIDTH
- w_ovf  out  1  sticky: write attempted while full

## Operation
- Write accept: wr_en = w_inc & ~w_full. On accept, array[wbin[ADDR_WIDTH-1:0]] <= w_data and wbin <= wbin+1. wbin is ADDR_WIDTH+1 bits and wraps modulo 2^(ADDR_WIDTH+1).
- w_gptr: registered as wbin_next ^ (wbin_next >> 1). Exactly one bit changes per accepted write.
- Synchroniser: r_gptr passes through SYNC_STAGES flops to give rq_gptr. rq_gptr is converted Gray→binary to give rq_bin.
- Full: w_full <= (wgray_next == {~rq_gptr[MSB:MSB-1], rq_gptr[MSB-2:0]}).
- Occupancy: w_count <= (wbin_next − rq_bin) mod 2^(ADDR_WIDTH+1). w_afull <= (that value ≥ AFULL_THRESH).
- Overflow: w_inc & w_full sets w_ovf on the next edge. The array and wbin are unchanged. w_ovf_clr clears w_ovf. If set and clear occur in the same cycle, set wins.
- Read port: r_data = array[r_addr], purely combinational. No read enable and no read-side state in this block.
- Reset (asynchronous, any time including mid-burst): wbin = 0, w_gptr = 0, all synchroniser flops = 0, w_full = 0, w_afull = 0, w_count = 0, w_ovf = 0, all array words = 0. So r_data = 0 while in reset.
- w_data is ignored when no write is accepted. No other state machine exists; pointer and flags are the only state.

## Timing
- Write at edge N: the word is visible on r_data (with matching r_addr) after edge N. w_gptr, w_count, w_full and w_afull reflect the write after edge N (zero latency for write-side effects).
- Full is pessimistic. A change on r_gptr reaches w_full/w_count/w_afull after SYNC_STAGES+1 w_clk edges.
- Simultaneous write and read-pointer advance: the count uses wbin_next and the current rq_bin. The read shows up later through the synchroniser, and no error results.
- Write on the cycle full asserts: the write that fills the FIFO is accepted. Any write on a following cycle while w_full=1 is dropped and flagged.
- Reset release: the first write is accepted on the first edge with w_rst=1 and w_inc=1.

## Test plan
- Reset: hold w_rst=0 with random inputs → all outputs 0, r_data=0 for every r_addr.
- Fill (defaults), r_gptr=0: write 0x01..0x08 on consecutive edges.
  - w_afull rises after the 6th edge; w_full and w_count=8 after the 8th.
  - w_gptr sequence is 0001,0011,0010,0110,0111,0101,0100,1100.
  - r_addr=0..7 returns 0x01..0x08.
- Overflow: from full, w_inc=1 with w_data=0xFF → array unchanged, wbin unchanged, w_ovf=1 next edge. w_ovf_clr=1 together with another blocked write → w_ovf stays 1. Clear alone → 0.
- Drain release: from full, set r_gptr=0010 (binary 3) → w_full drops and w_count=5 exactly 3 edges later; w_afull drops at the same edge.
- Wrap-around: 40 writes with r_gptr tracking 2 entries behind → w_full never asserts. wbin wraps through 15→0 and Gray continuity holds. Read data matches write order.
- Reset mid-burst: assert w_rst after 5 writes, asynchronously between edges → outputs go 0 immediately. After release, a write of 0xA5 lands at address 0.

Source files
------------

// File: rtl/fifo_wr_mem_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fifo_wr_mem_ctrl
//
// Write-domain half of an asynchronous FIFO, clocked by w_clk. It holds the
// dual-port storage array, the binary write pointer and its registered Gray
// export, the synchroniser that brings the read-domain Gray pointer into
// w_clk, and the full / almost-full / occupancy / sticky-overflow status.
// The array is read combinationally by the read domain through r_addr.
//
// Parameters
//   DATA_WIDTH   : width of one FIFO word
//   ADDR_WIDTH   : address bits, depth = 2**ADDR_WIDTH (>= 2)
//   SYNC_STAGES  : flops on the r_gptr crossing (>= 2)
//   AFULL_THRESH : occupancy at or above which w_afull asserts
//                  (1 .. 2**ADDR_WIDTH)
//
// Ports
//   w_clk      in   write clock
//   w_rst      in   asynchronous reset, active low
//   w_inc      in   write request
//   w_data     in   write data
//   w_ovf_clr  in   synchronous clear of the sticky overflow flag
//   r_addr     in   binary read address from the read domain
//   r_gptr     in   Gray read pointer from the read domain (async to w_clk)
//   r_data     out  array[r_addr], combinational
//   w_gptr     out  registered Gray write pointer for the read domain
//   w_full     out  FIFO full, registered
//   w_afull    out  occupancy >= AFULL_THRESH, registered
//   w_count    out  write-side occupancy, registered, 0 .. 2**ADDR_WIDTH
//   w_ovf      out  sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module fifo_wr_mem_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_ovf_clr,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [ADDR_WIDTH:0]   r_gptr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [ADDR_WIDTH:0]   w_gptr,
    output logic                  w_full,
    output logic                  w_afull,
    output logic [ADDR_WIDTH:0]   w_count,
    output logic                  w_ovf
);

    // Pointers carry one extra wrap bit beyond the address.
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    // -----------------------------------------------------------------------
    // Gray code helpers
    // -----------------------------------------------------------------------
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wbin_q;
    logic [PW-1:0]         wgray_q;
    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic                  full_q;
    logic                  afull_q;
    logic [PW-1:0]         count_q;
    logic                  ovf_q;

    // -----------------------------------------------------------------------
    // Next-state terms
    // -----------------------------------------------------------------------
    logic          wr_en;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] wgray_d;
    logic [PW-1:0] rq_gptr;
    logic [PW-1:0] rq_bin;
    logic [PW-1:0] full_pat;
    logic          full_d;
    logic          afull_d;
    logic [PW-1:0] count_d;
    logic          ovf_d;

    always_comb begin
        wr_en   = w_inc & ~full_q;
        wbin_d  = wr_en ? (wbin_q + PTR_ONE) : wbin_q;
        wgray_d = bin2gray(wbin_d);

        rq_gptr = sync_q[SYNC_STAGES-1];
        rq_bin  = gray2bin(rq_gptr);

        // The write pointer is exactly one lap ahead of the read pointer
        // when its Gray code equals the read Gray code with the two top
        // bits inverted. Using the stale synchronised pointer only ever
        // makes full assert early, never late.
        full_pat = {~rq_gptr[PW-1:PW-2], rq_gptr[PW-3:0]};
        full_d   = (wgray_d == full_pat);

        // Modular difference; the extra wrap bit lets 0 and DEPTH differ.
        count_d = wbin_d - rq_bin;
        afull_d = (count_d >= AFULL_LVL);

        // Set has priority over clear so an overflow in the clearing
        // cycle is never lost.
        ovf_d = ovf_q;
        if (w_inc & full_q) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array: written at the current binary pointer, cleared on reset
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

    // -----------------------------------------------------------------------
    // Read-pointer synchroniser: only Gray values cross, so at most one bit
    // is in flight and every sampled value is a real pointer position.
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= r_gptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write pointer and status flags
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_gptr  = wgray_q;
    assign w_full  = full_q;
    assign w_afull = afull_q;
    assign w_count = count_q;
    assign w_ovf   = ovf_q;

endmodule

// File: tb/tb_fifo_wr_mem_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fifo_wr_mem_ctrl
//
// Self-checking bench for the write half of the async FIFO. A reference
// model tracks the FIFO as pointer counts and a data queue; the read
// pointer crossing is modelled as a plain delay line of binary pointer
// values.
// ---------------------------------------------------------------------------
module tb_fifo_wr_mem_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 1 << PW;
    localparam int SYNC  = 2;
    localparam int ATH   = 6;

    logic          w_clk;
    logic          w_rst;
    logic          w_inc;
    logic [DW-1:0] w_data;
    logic          w_ovf_clr;
    logic [AW-1:0] r_addr;
    logic [PW-1:0] r_gptr;
    logic [DW-1:0] r_data;
    logic [PW-1:0] w_gptr;
    logic          w_full;
    logic          w_afull;
    logic [PW-1:0] w_count;
    logic          w_ovf;

    fifo_wr_mem_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SYNC),
        .AFULL_THRESH(ATH)
    ) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_inc    (w_inc),
        .w_data   (w_data),
        .w_ovf_clr(w_ovf_clr),
        .r_addr   (r_addr),
        .r_gptr   (r_gptr),
        .r_data   (r_data),
        .w_gptr   (w_gptr),
        .w_full   (w_full),
        .w_afull  (w_afull),
        .w_count  (w_count),
        .w_ovf    (w_ovf)
    );

    initial w_clk = 1'b0;
    always #10 w_clk = ~w_clk;

    int n_chk;
    int n_fail;

    task automatic chk_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           wptr_m;
    int           rdly_m [SYNC];
    bit           full_m;
    bit           afull_m;
    bit           ovf_m;
    int           count_m;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] wq [$];
    bit           last_acc;

    function automatic logic [PW-1:0] to_gray(input int b);
        int g;
        g = b ^ (b >> 1);
        return g[PW-1:0];
    endfunction

    task automatic model_reset();
        wptr_m  = 0;
        full_m  = 0;
        afull_m = 0;
        ovf_m   = 0;
        count_m = 0;
        for (int i = 0; i < SYNC; i++) rdly_m[i] = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        wq.delete();
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input bit inc, input logic [DW-1:0] d, input bit clr,
                        input int rbin);
        int rq;
        int occ;
        bit acc;
        w_inc     = inc;
        w_data    = d;
        w_ovf_clr = clr;
        r_gptr    = to_gray(rbin);
        rq  = rdly_m[SYNC-1];
        acc = inc && !full_m;
        if (acc) begin
            mem_m[wptr_m % DEPTH] = d;
            wq.push_back(d);
            wptr_m = (wptr_m + 1) % MOD;
        end
        if (inc && full_m) ovf_m = 1;
        else if (clr)      ovf_m = 0;
        occ     = (wptr_m - rq + MOD) % MOD;
        count_m = occ;
        full_m  = (occ == DEPTH);
        afull_m = (occ >= ATH);
        for (int i = SYNC - 1; i > 0; i--) rdly_m[i] = rdly_m[i-1];
        rdly_m[0] = rbin;
        @(posedge w_clk);
        #1;
        chk_eq("gptr",  32'(w_gptr),  32'(to_gray(wptr_m)));
        chk_eq("full",  32'(w_full),  32'(full_m));
        chk_eq("afull", 32'(w_afull), 32'(afull_m));
        chk_eq("count", 32'(w_count), 32'(count_m));
        chk_eq("ovf",   32'(w_ovf),   32'(ovf_m));
        last_acc = acc;
    endtask

    task automatic chk_array(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            r_addr = a[AW-1:0];
            #1;
            chk_eq(tag, 32'(r_data), 32'(mem_m[a]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_gptr"},  32'(w_gptr),  0);
        chk_eq({tag, "_full"},  32'(w_full),  0);
        chk_eq({tag, "_afull"}, 32'(w_afull), 0);
        chk_eq({tag, "_count"}, 32'(w_count), 0);
        chk_eq({tag, "_ovf"},   32'(w_ovf),   0);
        for (int a = 0; a < DEPTH; a++) begin
            r_addr = a[AW-1:0];
            #0.5;
            chk_eq({tag, "_rdata"}, 32'(r_data), 0);
        end
    endtask

    int exp_g [DEPTH] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        int rd;
        int acc_n;
        int guard;
        int nr;
        logic [PW-1:0] prev_g;
        logic [DW-1:0] exp_d;

        n_chk     = 0;
        n_fail    = 0;
        w_rst     = 1'b0;
        w_inc     = 1'b0;
        w_data    = '0;
        w_ovf_clr = 1'b0;
        r_addr    = '0;
        r_gptr    = '0;
        model_reset();

        // Reset held with random inputs toggling.
        for (int c = 0; c < 4; c++) begin
            @(posedge w_clk);
            #1;
            w_inc     = 1'($urandom);
            w_data    = 8'($urandom);
            w_ovf_clr = 1'($urandom);
            r_gptr    = 4'($urandom);
            chk_all_zero("rst");
        end

        // Release between edges with quiet inputs.
        w_inc  = 1'b0;
        r_gptr = '0;
        w_rst  = 1'b1;

        // Fill 0x01..0x08 with the read pointer parked at 0.
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 8'(k + 1), 0, 0);
            chk_eq("fill_gseq", 32'(w_gptr), 32'(exp_g[k]));
            chk_eq("fill_afull", 32'(w_afull), (k + 1 >= ATH) ? 1 : 0);
            chk_eq("fill_full",  32'(w_full),  (k + 1 == DEPTH) ? 1 : 0);
        end
        chk_eq("fill_count8", 32'(w_count), 8);
        for (int a = 0; a < DEPTH; a++) begin
            r_addr = a[AW-1:0];
            #1;
            chk_eq("fill_rdata", 32'(r_data), a + 1);
        end

        // Overflow: blocked write, then set+clear together, then clear alone.
        step(1, 8'hFF, 0, 0);
        chk_eq("ovf_set", 32'(w_ovf), 1);
        chk_eq("ovf_gptr_hold", 32'(w_gptr), 32'(exp_g[DEPTH-1]));
        chk_array("ovf_array");
        step(1, 8'hEE, 1, 0);
        chk_eq("ovf_set_wins", 32'(w_ovf), 1);
        step(0, 8'h00, 1, 0);
        chk_eq("ovf_clr", 32'(w_ovf), 0);
        chk_array("ovf_array2");

        // Drain release: read pointer jumps to 3; seen three edges later.
        step(0, 8'h00, 0, 3);
        chk_eq("drain_e1_full", 32'(w_full), 1);
        step(0, 8'h00, 0, 3);
        chk_eq("drain_e2_full", 32'(w_full), 1);
        step(0, 8'h00, 0, 3);
        chk_eq("drain_e3_full",  32'(w_full),  0);
        chk_eq("drain_e3_count", 32'(w_count), 5);
        chk_eq("drain_e3_afull", 32'(w_afull), 0);

        // Words 1..3 are consumed by the read side.
        rd = 3;
        for (int i = 0; i < 3; i++) begin
            r_addr = i[AW-1:0];
            #1;
            exp_d = wq.pop_front();
            chk_eq("drain_rdata", 32'(r_data), 32'(exp_d));
        end

        // Wrap-around: 40 accepted writes, reader trailing two entries.
        acc_n = 0;
        guard = 0;
        while (acc_n < 40 && guard < 400) begin
            guard++;
            nr = 0;
            while (((wptr_m - rd + MOD) % MOD) > 2 && nr < 2) begin
                r_addr = 3'(rd % DEPTH);
                #1;
                exp_d = wq.pop_front();
                chk_eq("wrap_rdata", 32'(r_data), 32'(exp_d));
                rd = (rd + 1) % MOD;
                nr++;
            end
            prev_g = w_gptr;
            step(($urandom_range(0, 3) != 0), 8'($urandom), 0, rd);
            if (last_acc) begin
                acc_n++;
                chk_eq("wrap_gray1bit", $countones(prev_g ^ w_gptr), 1);
            end
            chk_eq("wrap_nofull", 32'(w_full), 0);
        end
        chk_eq("wrap_done", acc_n, 40);

        // Reset mid-burst, asserted between edges.
        for (int k = 0; k < 5; k++) begin
            step(1, 8'($urandom), 0, rd);
        end
        #2;
        w_rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        rd     = 0;
        w_inc  = 1'b0;
        r_gptr = '0;
        #2;
        w_rst = 1'b1;
        step(1, 8'hA5, 0, 0);
        r_addr = '0;
        #1;
        chk_eq("post_rst_rdata", 32'(r_data), 32'h000000A5);
        chk_eq("post_rst_count", 32'(w_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
